pipelined_prefix_adder: RTL and testbench

Parametrised, pipelined Sklansky-style parallel-prefix adder/subtractor with a valid/ready stream interface.
It is the generalised successor of the team's fixed 16-bit combinational prefix adder, adding:
- configurable width and pipeline depth
- a per-operation add/sub mode
- signed-overflow and zero flags
- a sideband tag
- backpressure
It sits in the arithmetic library as the adder core for datapaths that need high clock rates.

---
 rtl/pipelined_prefix_adder_pkg.sv | 27 ++
 rtl/pipelined_prefix_adder_if.sv | 36 +++
 rtl/pipelined_prefix_adder_level.sv | 39 +++
 rtl/pipelined_prefix_adder.sv | 152 +++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_prefix_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module : prefix_adder_pkg
// Shared operation type and elaboration helpers for the pipelined prefix adder.
// Rev    : 1.0
// ============================================================================
package prefix_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // True when a register rank follows prefix level l.
    function automatic bit stage_after(input int l, input int stages, input int log2w);
        return (((l + 1) * stages) / (log2w + 1)) > ((l * stages) / (log2w + 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_prefix_adder_if.sv
`default_nettype none
// ============================================================================
// Module : pipelined_prefix_adder_if
// Valid/ready operand and result streams of the pipelined prefix adder.
// Rev    : 1.0
// ============================================================================
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_prefix_adder_level.sv
`default_nettype none
// ============================================================================
// Module : prefix_level
// One combinational Sklansky level; vector position 0 holds bit -1 (carry-in).
// Rev    : 1.0
// ============================================================================
module prefix_level #(
    parameter int WIDTH = 32,
    parameter int LEVEL = 1
) (
    input  logic [WIDTH:0] i_p,
    input  logic [WIDTH:0] i_g,
    output logic [WIDTH:0] o_p,
    output logic [WIDTH:0] o_g
);
    localparam int BLK  = 1 << LEVEL;
    localparam int HALF = 1 << (LEVEL - 1);

    assign o_p[0] = i_p[0];
    assign o_g[0] = i_g[0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int K = (i / BLK) * BLK + HALF - 1;
        if (((i / HALF) % 2) == 1) begin : g_cell
            // Partner group already reaches bit -1 below BLK, so only G matters.
            if (i < BLK) begin : g_gray
                assign o_g[i+1] = i_g[i+1] | (i_p[i+1] & i_g[K+1]);
                assign o_p[i+1] = 1'b0;
            end else begin : g_black
                assign o_g[i+1] = i_g[i+1] | (i_p[i+1] & i_g[K+1]);
                assign o_p[i+1] = i_p[i+1] & i_p[K+1];
            end
        end else begin : g_pass
            assign o_g[i+1] = i_g[i+1];
            assign o_p[i+1] = i_p[i+1];
        end
    end
endmodule
`default_nettype wire

// File: rtl/pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module : pipelined_prefix_adder
// Pipelined Sklansky adder/subtractor with flags, tag and global-stall handshake.
// Rev    : 1.0
// ============================================================================
module pipelined_prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    nReset,
    pipelined_prefix_adder_if.slave bus
);
    localparam int LOG2W = clog2(WIDTH);

    if (WIDTH < 8 || WIDTH > 64 || (1 << LOG2W) != WIDTH ||
        STAGES < 1 || STAGES > LOG2W + 1 || TAG_W < 1) begin : g_param_check
        $error("pipelined_prefix_adder: parameter out of range");
    end

    logic             w_adv;
    logic [WIDTH:0]   w_p   [0:LOG2W];
    logic [WIDTH:0]   w_g   [0:LOG2W];
    logic [WIDTH-1:0] w_po  [0:LOG2W];
    logic [TAG_W-1:0] w_tag [0:LOG2W];
    logic             w_vld [0:LOG2W];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [TAG_W-1:0] r_tag;

    assign w_adv        = bus.out_ready | ~r_out_valid;
    assign bus.in_ready = w_adv;

    for (genvar l = 0; l <= LOG2W; l++) begin : g_lvl
        logic [WIDTH:0]   w_lp;
        logic [WIDTH:0]   w_lg;
        logic [WIDTH-1:0] w_lpo;
        logic [TAG_W-1:0] w_ltag;
        logic             w_lvld;

        if (l == 0) begin : g_prep
            logic             w_sub;
            logic [WIDTH-1:0] w_bm;
            logic [WIDTH-1:0] w_gen;
            logic             w_c0;
            assign w_sub  = (op_e'(bus.in_op) == OP_SUB);
            assign w_bm   = w_sub ? ~bus.in_b : bus.in_b;
            assign w_c0   = w_sub | bus.in_cin;
            assign w_lpo  = bus.in_a ^ w_bm;
            assign w_gen  = bus.in_a & w_bm;
            // Bit 0 absorbs the bit -1 generate here, so every group reaching bit 0 carries c0.
            assign w_lp   = {w_lpo[WIDTH-1:1], 2'b00};
            assign w_lg   = {w_gen[WIDTH-1:1], w_gen[0] | (w_lpo[0] & w_c0), w_c0};
            assign w_ltag = bus.in_tag;
            assign w_lvld = bus.in_valid & w_adv;
        end else begin : g_net
            prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (l)
            ) u_level (
                .i_p (w_p[l-1]),
                .i_g (w_g[l-1]),
                .o_p (w_lp),
                .o_g (w_lg)
            );
            assign w_lpo  = w_po[l-1];
            assign w_ltag = w_tag[l-1];
            assign w_lvld = w_vld[l-1];
        end

        if (l < LOG2W && stage_after(l, STAGES, LOG2W)) begin : g_rank
            logic [WIDTH:0]   r_p;
            logic [WIDTH:0]   r_g;
            logic [WIDTH-1:0] r_po;
            logic [TAG_W-1:0] r_rtag;
            logic             r_vld;
            always_ff @(posedge clk or negedge nReset) begin
                if (!nReset) begin
                    r_p    <= '0;
                    r_g    <= '0;
                    r_po   <= '0;
                    r_rtag <= '0;
                    r_vld  <= 1'b0;
                end else if (w_adv) begin
                    r_p    <= w_lp;
                    r_g    <= w_lg;
                    r_po   <= w_lpo;
                    r_rtag <= w_ltag;
                    r_vld  <= w_lvld;
                end
            end
            assign w_p[l]   = r_p;
            assign w_g[l]   = r_g;
            assign w_po[l]  = r_po;
            assign w_tag[l] = r_rtag;
            assign w_vld[l] = r_vld;
        end else begin : g_wire
            assign w_p[l]   = w_lp;
            assign w_g[l]   = w_lg;
            assign w_po[l]  = w_lpo;
            assign w_tag[l] = w_ltag;
            assign w_vld[l] = w_lvld;
        end
    end

    // Position j of the final G vector is the carry into bit j (carry out of bit j-1).
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_zero;
    logic             w_unused_p;

    assign w_sum      = w_po[LOG2W] ^ w_g[LOG2W][WIDTH-1:0];
    assign w_cout     = w_g[LOG2W][WIDTH];
    assign w_ovf      = w_g[LOG2W][WIDTH-1] ^ w_cout;
    assign w_zero     = ~|w_sum;
    assign w_unused_p = ^w_p[LOG2W];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_tag       <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_vld[LOG2W];
            r_sum       <= w_sum;
            r_cout      <= w_cout;
            r_ovf       <= w_ovf;
            r_zero      <= w_zero;
            r_tag       <= w_tag[LOG2W];
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_zero  = r_zero;
    assign bus.out_tag   = r_tag;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_pipelined_prefix_adder
// Directed vectors, stall/reset sequences and randomized model checks.
// Rev    : 1.0
// ============================================================================
module tb_pipelined_prefix_adder;
    import prefix_adder_pkg::*;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int S  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic rnd_rst_n;
    int   total    = 0;
    int   bad      = 0;
    int   rnd_done = 0;

    always #5 clk = ~clk;

    pipelined_prefix_adder_if #(.WIDTH(W), .TAG_W(TW)) m_bus ();

    pipelined_prefix_adder #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) u_dut (
        .clk    (clk),
        .nReset (rst_n),
        .bus    (m_bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          cin;
        op_e           op;
        logic [TW-1:0] tag;
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic          zero;
    } vec_t;

    vec_t vt [8];

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        m_bus.in_valid  = 1'b1;
        m_bus.in_a      = v.a;
        m_bus.in_b      = v.b;
        m_bus.in_cin    = v.cin;
        m_bus.in_op     = v.op;
        m_bus.in_tag    = v.tag;
        m_bus.out_ready = 1'b1;
        #1 check($sformatf("vec%0d_in_ready", idx), 128'(m_bus.in_ready), 128'(1));
        @(negedge clk);
        m_bus.in_valid = 1'b0;
        lat = 1;
        while (!m_bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), 128'(lat), 128'(S));
        check($sformatf("vec%0d_sum", idx),  128'(m_bus.out_sum),  128'(v.sum));
        check($sformatf("vec%0d_cout", idx), 128'(m_bus.out_cout), 128'(v.cout));
        check($sformatf("vec%0d_ovf", idx),  128'(m_bus.out_ovf),  128'(v.ovf));
        check($sformatf("vec%0d_zero", idx), 128'(m_bus.out_zero), 128'(v.zero));
        check($sformatf("vec%0d_tag", idx),  128'(m_bus.out_tag),  128'(v.tag));
        @(negedge clk);
        check($sformatf("vec%0d_no_dup", idx), 128'(m_bus.out_valid), 128'(0));
    endtask

    initial begin : p_main
        logic [W-1:0]  exp_s [6];
        logic [W-1:0]  held_sum;
        logic [TW-1:0] held_tag;
        int            n_sent;
        int            n_got;
        int            seen_valid;

        rst_n           = 1'b0;
        rnd_rst_n       = 1'b0;
        m_bus.in_valid  = 1'b0;
        m_bus.in_a      = '0;
        m_bus.in_b      = '0;
        m_bus.in_cin    = 1'b0;
        m_bus.in_op     = 1'b0;
        m_bus.in_tag    = '0;
        m_bus.out_ready = 1'b0;

        //          a             b             cin   op      tag    sum           cout  ovf   zero
        vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, OP_ADD, 4'h1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{32'h00000005, 32'h00000007, 1'b0, OP_SUB, 4'h2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vt[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, OP_ADD, 4'h3, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[3] = '{32'h00000010, 32'h00000020, 1'b1, OP_ADD, 4'hA, 32'h00000031, 1'b0, 1'b0, 1'b0};
        vt[4] = '{32'h00000005, 32'h00000007, 1'b1, OP_SUB, 4'h5, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vt[5] = '{32'h80000000, 32'h00000001, 1'b0, OP_SUB, 4'h6, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vt[6] = '{32'h00001234, 32'h00001234, 1'b1, OP_SUB, 4'h7, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[7] = '{32'h80000000, 32'h80000000, 1'b0, OP_ADD, 4'hF, 32'h00000000, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 128'(m_bus.out_valid), 128'(0));
        check("reset_out_sum",   128'(m_bus.out_sum),   128'(0));
        check("reset_out_flags", 128'({m_bus.out_cout, m_bus.out_ovf, m_bus.out_zero}), 128'(0));
        check("reset_out_tag",   128'(m_bus.out_tag),   128'(0));
        check("reset_in_ready",  128'(m_bus.in_ready),  128'(1));
        @(negedge clk);
        rst_n     = 1'b1;
        rnd_rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Six back-to-back ops with out_ready dropped in cycles 4 and 5.
        n_sent = 0;
        n_got  = 0;
        held_sum = '0;
        held_tag = '0;
        for (int i = 0; i < 6; i++) exp_s[i] = 32'h01010101 * (i + 1) + 32'(i * 3);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            m_bus.out_ready = !(k == 4 || k == 5);
            m_bus.in_valid  = (n_sent < 6);
            m_bus.in_a      = 32'h01010101 * (n_sent + 1);
            m_bus.in_b      = 32'(n_sent * 3);
            m_bus.in_cin    = 1'b0;
            m_bus.in_op     = OP_ADD;
            m_bus.in_tag    = 4'(n_sent);
            #1;
            check($sformatf("stall_in_ready_c%0d", k), 128'(m_bus.in_ready),
                  128'((k == 4 || k == 5) ? 0 : 1));
            if (k == 4) begin
                held_sum = m_bus.out_sum;
                held_tag = m_bus.out_tag;
            end
            if (k == 5) begin
                check("stall_hold_sum", 128'(m_bus.out_sum), 128'(held_sum));
                check("stall_hold_tag", 128'(m_bus.out_tag), 128'(held_tag));
                check("stall_hold_valid", 128'(m_bus.out_valid), 128'(1));
            end
            if (m_bus.out_valid && m_bus.out_ready) begin
                if (n_got < 6) begin
                    check($sformatf("stall_sum%0d", n_got), 128'(m_bus.out_sum), 128'(exp_s[n_got]));
                    check($sformatf("stall_tag%0d", n_got), 128'(m_bus.out_tag), 128'(n_got));
                end else begin
                    check("stall_extra_result", 128'(1), 128'(0));
                end
                n_got++;
            end
            if (m_bus.in_valid && m_bus.in_ready) n_sent++;
        end
        m_bus.in_valid = 1'b0;
        check("stall_result_count", 128'(n_got), 128'(6));

        // Two ops in flight, first one parked at the output, then async reset.
        @(negedge clk);
        m_bus.out_ready = 1'b0;
        m_bus.in_valid  = 1'b1;
        m_bus.in_a      = 32'h00000100;
        m_bus.in_b      = 32'h00000023;
        m_bus.in_tag    = 4'h9;
        @(negedge clk);
        m_bus.in_a      = 32'h00000200;
        @(negedge clk);
        m_bus.in_valid  = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("rst_pre_out_valid", 128'(m_bus.out_valid), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", 128'(m_bus.out_valid), 128'(0));
        check("rst_async_out_sum",   128'(m_bus.out_sum),   128'(0));
        check("rst_async_in_ready",  128'(m_bus.in_ready),  128'(1));
        #1 rst_n = 1'b1;
        m_bus.out_ready = 1'b1;
        seen_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (m_bus.out_valid) seen_valid++;
        end
        check("rst_nothing_after", 128'(seen_valid), 128'(0));
        check("rst_in_ready_after", 128'(m_bus.in_ready), 128'(1));

        for (int i = 0; i < 30000 && rnd_done < 6; i++) @(negedge clk);
        check("rnd_all_configs_done", 128'(rnd_done), 128'(6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    localparam int NCFG = 6;
    localparam int CFG_W [NCFG] = '{8, 8, 16, 16, 64, 64};

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int RW   = CFG_W[c];
        localparam int RL   = $clog2(RW);
        localparam int RS   = ((c % 2) == 0) ? 1 : RL + 1;
        localparam int NOPS = 1700;
        localparam int RB   = RW + TW + 3;

        pipelined_prefix_adder_if #(.WIDTH(RW), .TAG_W(TW)) r_bus ();

        pipelined_prefix_adder #(.WIDTH(RW), .STAGES(RS), .TAG_W(TW)) u_dut (
            .clk    (clk),
            .nReset (rnd_rst_n),
            .bus    (r_bus)
        );

        logic [RB-1:0] q [$];

        initial begin : p_rnd
            logic [63:0]         ra;
            logic [63:0]         rb;
            logic [RW-1:0]       a;
            logic [RW-1:0]       b;
            logic signed [RW+1:0] sa;
            logic signed [RW+1:0] sb;
            logic signed [RW+1:0] sr;
            logic [RW:0]         us;
            logic                cout;
            logic [RB-1:0]       e;
            logic [RB-1:0]       cur;
            logic [RB-1:0]       held;
            logic                held_vld;
            int                  n_acc;
            int                  n_out;
            int                  cyc;
            string               nm;

            nm = $sformatf("rnd_w%0d_s%0d", RW, RS);
            r_bus.in_valid  = 1'b0;
            r_bus.in_a      = '0;
            r_bus.in_b      = '0;
            r_bus.in_cin    = 1'b0;
            r_bus.in_op     = 1'b0;
            r_bus.in_tag    = '0;
            r_bus.out_ready = 1'b0;
            held     = '0;
            held_vld = 1'b0;
            n_acc    = 0;
            n_out    = 0;
            cyc      = 0;
            wait (rnd_rst_n === 1'b1);
            while (n_out < NOPS && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                a  = ra[RW-1:0];
                b  = rb[RW-1:0];
                case ($urandom_range(0, 7))
                    0: a = '1;
                    1: b = '0;
                    2: b = a;
                    3: a = {1'b0, {(RW-1){1'b1}}};
                    default: ;
                endcase
                r_bus.out_ready = ($urandom_range(0, 3) != 0);
                r_bus.in_valid  = (n_acc < NOPS) && ($urandom_range(0, 3) != 0);
                r_bus.in_a      = a;
                r_bus.in_b      = b;
                r_bus.in_cin    = 1'($urandom);
                r_bus.in_op     = 1'($urandom);
                r_bus.in_tag    = 4'($urandom);
                #1;
                cur = {r_bus.out_sum, r_bus.out_cout, r_bus.out_ovf, r_bus.out_zero, r_bus.out_tag};
                if (held_vld) begin
                    check({nm, "_held"}, 128'({r_bus.out_valid, cur}), 128'({1'b1, held}));
                end
                held_vld = r_bus.out_valid && !r_bus.out_ready;
                held     = cur;
                if (r_bus.out_valid && r_bus.out_ready) begin
                    if (q.size() == 0) begin
                        check({nm, "_spurious"}, 128'(1), 128'(0));
                    end else begin
                        e = q.pop_front();
                        check({nm, "_result"}, 128'(cur), 128'(e));
                    end
                    n_out++;
                end
                if (r_bus.in_valid && r_bus.in_ready) begin
                    sa = {{2{a[RW-1]}}, a};
                    sb = {{2{b[RW-1]}}, b};
                    if (r_bus.in_op) begin
                        sr   = sa - sb;
                        cout = (a >= b);
                    end else begin
                        sr   = sa + sb + {{(RW+1){1'b0}}, r_bus.in_cin};
                        us   = {1'b0, a} + {1'b0, b} + {{RW{1'b0}}, r_bus.in_cin};
                        cout = us[RW];
                    end
                    q.push_back({sr[RW-1:0], cout, sr[RW] != sr[RW-1],
                                 sr[RW-1:0] == '0, r_bus.in_tag});
                    n_acc++;
                end
            end
            r_bus.in_valid = 1'b0;
            check({nm, "_count"}, 128'(n_out), 128'(NOPS));
            rnd_done++;
        end
    end
endmodule
`default_nettype wire
